// File: rtl/census_transform_frame.sv
// Frame-aware streaming census transform.
// Builds a WW x WH window from a register shift chain of raster pixels. Each
// emitted word compares the selected neighbours against centre + i_thr.
// Words for centres within the half-window of an image edge are flagged and
// zeroed. A self-timed flush drains the last L centres of every frame.
module census_transform_frame #(
  parameter int WW     = 3,
  parameter int WH     = 3,
  parameter int M      = 50,
  parameter int H      = 50,
  parameter int N      = 8,
  parameter int SPARSE = 1,
  localparam int CW    = (SPARSE != 0) ? (WW * WH) / 2 : WW * WH - 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_data,
  input  logic          i_dval,
  input  logic          i_sof,
  input  logic [N-1:0]  i_thr,
  output logic          o_ready,
  output logic [CW-1:0] o_data,
  output logic          o_dval,
  output logic          o_border,
  output logic          o_eof
);

  localparam int HH   = (WW - 1) / 2;
  localparam int VV   = (WH - 1) / 2;
  localparam int L    = VV * M + HH;
  localparam int SL   = (WH - 1) * M + WW;
  localparam int NPIX = M * H;
  localparam int KW   = $clog2(NPIX + 1);
  localparam int FW   = $clog2(L + 1);
  localparam int XW   = $clog2(M + 1);
  localparam int YW   = $clog2(H + 1);

  localparam logic [KW-1:0] L_K    = KW'(L);
  localparam logic [KW-1:0] LAST_K = KW'(NPIX - 1);
  localparam logic [FW-1:0] LAST_F = FW'(L - 1);
  localparam logic [XW-1:0] X_LO   = XW'(HH);
  localparam logic [XW-1:0] X_HI   = XW'(M - HH);
  localparam logic [XW-1:0] X_END  = XW'(M - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(VV);
  localparam logic [YW-1:0] Y_HI   = YW'(H - VV);
  localparam logic [YW-1:0] Y_END  = YW'(H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  // Cell (r,c) participates in the census word.
  function automatic bit is_sel(input int r, input int c);
    if (SPARSE != 0) return ((r + c) % 2) == 1;
    return !(r == VV && c == HH);
  endfunction

  // Number of selected cells preceding (r,c) in raster order.
  function automatic int sel_before(input int r, input int c);
    int n;
    n = 0;
    for (int i = 0; i < r * WW + c; i++) begin
      if (is_sel(i / WW, i % WW)) n++;
    end
    return n;
  endfunction

  // One census bit; the sum is widened by one bit so it never wraps.
  function automatic logic census_bit(input logic [N-1:0] nb,
                                      input logic [N-1:0] ctr,
                                      input logic [N-1:0] thr);
    logic [N:0] lim;
    lim = {1'b0, ctr} + {1'b0, thr};
    return {1'b0, nb} <= lim;
  endfunction

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [FW-1:0] fcnt;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [N-1:0]  chain      [SL];
  logic [N-1:0]  chain_next [SL];
  logic [N-1:0]  centre;
  logic [CW-1:0] word;
  logic          flushing, accept, advance, emit, border, last_ctr;
  logic [CW-1:0] data_p1;
  logic          vld_p1, border_p1, eof_p1;

  assign flushing = (state == S_FLUSH);
  assign o_ready  = !flushing;
  assign accept   = i_dval && !flushing;
  assign advance  = flushing || (accept && (state != S_IDLE || i_sof));
  assign emit     = flushing ||
                    (accept && !i_sof && state != S_IDLE && k >= L_K);
  assign border   = (px < X_LO) || (px >= X_HI) || (py < Y_LO) || (py >= Y_HI);
  assign last_ctr = (px == X_END) && (py == Y_END);

  // Chain contents after this cycle's shift; the word is built from these.
  always_comb begin
    chain_next[0] = flushing ? '0 : i_data;
    for (int i = 1; i < SL; i++) chain_next[i] = chain[i-1];
  end

  assign centre = chain_next[SL-1-(VV*M+HH)];

  for (genvar r = 0; r < WH; r++) begin : g_row
    for (genvar c = 0; c < WW; c++) begin : g_col
      if (is_sel(r, c)) begin : g_bit
        assign word[CW-1-sel_before(r, c)] =
          census_bit(chain_next[SL-1-(r*M+c)], centre, i_thr);
      end
    end
  end

  // Window shift chain: advances on every accepted in-frame pixel or flush cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SL; i++) chain[i] <= '0;
    end else if (advance) begin
      chain <= chain_next;
    end
  end

  // Frame FSM with pixel counter and flush counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k     <= '0;
      fcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && i_sof) begin
            state <= S_FILL;
            k     <= KW'(1);
          end
        end
        S_FILL, S_STREAM: begin
          if (accept) begin
            if (i_sof) begin
              state <= S_FILL;
              k     <= KW'(1);
            end else if (k == LAST_K) begin
              state <= S_FLUSH;
              k     <= '0;
              fcnt  <= '0;
            end else begin
              k <= k + KW'(1);
              if (state == S_FILL && k == L_K) state <= S_STREAM;
            end
          end
        end
        default: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == LAST_F) state <= S_IDLE;
        end
      endcase
    end
  end

  // Centre position tracker, restarted by every accepted start-of-frame pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      px <= '0;
      py <= '0;
    end else if (accept && i_sof) begin
      px <= '0;
      py <= '0;
    end else if (emit) begin
      if (px == X_END) begin
        px <= '0;
        py <= py + YW'(1);
      end else begin
        px <= px + XW'(1);
      end
    end
  end

  // Output stage: word, valid, border flag and end-of-frame marker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      eof_p1    <= 1'b0;
    end else begin
      data_p1   <= (emit && !border) ? word : '0;
      vld_p1    <= emit;
      border_p1 <= emit && border;
      eof_p1    <= emit && last_ctr;
    end
  end

  assign o_data   = data_p1;
  assign o_dval   = vld_p1;
  assign o_border = border_p1;
  assign o_eof    = eof_p1;

endmodule

// File: tb/tb_census_transform_frame.sv
// Bench for census_transform_frame: a sparse and a full-window instance share
// the same stimulus; an image-level reference model queues expected words.
module tb_census_transform_frame;

  localparam int M  = 4;
  localparam int H  = 3;
  localparam int V  = 1;
  localparam int HW = 1;
  localparam int L  = V * M + HW;
  localparam int NP = M * H;

  typedef struct {
    int         p;
    logic [3:0] ws;
    logic [7:0] wf;
    logic       b;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data, thr;
  logic       dval, sof;
  logic       rdy_s, rdy_f, dv_s, dv_f, bd_s, bd_f, eo_s, eo_f;
  logic [3:0] od_s;
  logic [7:0] od_f;

  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;
  int n_eof   = 0;
  exp_t sb[$];
  logic [3:0] seen[$];
  logic [3:0] ref_seq[$];
  logic [3:0] got5_s;
  logic [7:0] got5_f;

  int img[NP];
  int m_k = 0;
  bit m_active = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  census_transform_frame #(.WW(3), .WH(3), .M(M), .H(H), .N(8), .SPARSE(1)) u_sparse (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dval(dval), .i_sof(sof), .i_thr(thr),
    .o_ready(rdy_s), .o_data(od_s), .o_dval(dv_s), .o_border(bd_s), .o_eof(eo_s));

  census_transform_frame #(.WW(3), .WH(3), .M(M), .H(H), .N(8), .SPARSE(0)) u_full (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dval(dval), .i_sof(sof), .i_thr(thr),
    .o_ready(rdy_f), .o_data(od_f), .o_dval(dv_f), .o_border(bd_f), .o_eof(eo_f));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected census words for centre p from the image seen so far.
  function automatic exp_t model(input int p, input int t);
    exp_t e;
    int y, x, nb;
    bit bt;
    y = p / M;
    x = p % M;
    e.p  = p;
    e.e  = (p == NP - 1);
    e.b  = (y < V) || (y >= H - V) || (x < HW) || (x >= M - HW);
    e.ws = '0;
    e.wf = '0;
    if (!e.b) begin
      for (int dy = -V; dy <= V; dy++) begin
        for (int dx = -HW; dx <= HW; dx++) begin
          if (dy != 0 || dx != 0) begin
            nb = img[(y + dy) * M + x + dx];
            bt = (nb <= img[p] + t);
            e.wf = {e.wf[6:0], bt};
            if (((dy + dx) % 2) != 0) e.ws = {e.ws[2:0], bt};
          end
        end
      end
    end
    return e;
  endfunction

  // One clock cycle of stimulus; updates the frame model and queues expectations.
  task automatic cycle(input bit dv, input bit sf, input int d, input int t);
    @(negedge clk);
    dval = dv;
    sof  = sf;
    data = d[7:0];
    thr  = t[7:0];
    #1;
    chk("ready_sparse", rdy_s, m_flush == 0);
    chk("ready_full", rdy_f, m_flush == 0);
    if (m_flush > 0) begin
      sb.push_back(model(NP - m_flush, t));
      m_flush--;
      if (m_flush == 0) m_active = 0;
    end else if (dv) begin
      if (sf) begin
        m_active = 1;
        img[0]   = d;
        m_k      = 1;
      end else if (m_active) begin
        img[m_k] = d;
        if (m_k >= L) sb.push_back(model(m_k - L, t));
        if (m_k == NP - 1) m_flush = L;
        m_k++;
      end
    end
    @(posedge clk);
  endtask

  // kind: 0 constant 100, 1 ramp, 2 saturation, 3 random. t<0: random thr per cycle.
  // stall: 0 none, 1 alternate valid/gap, 2 random gaps.
  task automatic run_frame(input int kind, input int t, input int stall);
    int pix[NP];
    int tc;
    for (int i = 0; i < NP; i++) begin
      case (kind)
        0:       pix[i] = 100;
        1:       pix[i] = i * 10;
        2:       pix[i] = (i == 5) ? 250 : 255;
        default: pix[i] = $urandom_range(0, 255);
      endcase
    end
    if (kind == 3) begin
      cycle(1, 0, $urandom_range(0, 255), 0);
      cycle(1, 0, $urandom_range(0, 255), 0);
    end
    for (int i = 0; i < NP; i++) begin
      tc = (t < 0) ? $urandom_range(0, 40) : t;
      if (stall == 1 && i != 0) cycle(0, 0, $urandom_range(0, 255), tc);
      if (stall == 2) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) cycle(0, 0, $urandom_range(0, 255), tc);
      end
      cycle(1, i == 0, pix[i], tc);
    end
    for (int j = 0; j < L; j++) begin
      tc = (t < 0) ? $urandom_range(0, 40) : t;
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255), tc);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1;
    dval = 0;
    sof  = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    m_flush = 0;
    m_active = 0;
    m_k = 0;
    #1;
    chk("rst_dval", {dv_s, dv_f}, 2'b00);
    chk("rst_ready", {rdy_s, rdy_f}, 2'b11);
    chk("rst_data", {od_s, od_f}, 12'h000);
    chk("rst_border", {bd_s, bd_f}, 2'b00);
    chk("rst_eof", {eo_s, eo_f}, 2'b00);
  endtask

  // Monitor: every presented word must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (dv_s || dv_f) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got o_dval=%0b/%0b expected 0/0", dv_s, dv_f);
        end else begin
          e = sb.pop_front();
          chk("dval_pair", {dv_s, dv_f}, 2'b11);
          chk("word_sparse", od_s, e.ws);
          chk("word_full", od_f, e.wf);
          chk("border", {bd_s, bd_f}, {e.b, e.b});
          chk("eof", {eo_s, eo_f}, {e.e, e.e});
          n_words++;
          if (eo_s) n_eof++;
          if (e.p == 5) begin
            got5_s = od_s;
            got5_f = od_f;
          end
          seen.push_back(od_s);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, e0;
    rst = 1;
    dval = 0;
    sof = 0;
    data = 0;
    thr = 0;
    repeat (3) @(posedge clk);
    do_reset();

    // Constant frame
    w0 = n_words; e0 = n_eof;
    run_frame(0, 0, 0);
    chk("const_words", n_words - w0, 12);
    chk("const_eof", n_eof - e0, 1);

    // Ramp, thr 0
    got5_s = 0; got5_f = 0;
    seen.delete();
    run_frame(1, 0, 0);
    ref_seq = seen;
    chk("ramp_c11_sparse", got5_s, 4'b1100);
    chk("ramp_c11_full", got5_f, 8'b11110000);

    // Ramp, thr 15
    got5_s = 0;
    run_frame(1, 15, 0);
    chk("ramp_thr15_sparse", got5_s, 4'b1110);

    // Saturation: centre 250, neighbours 255, thr 255
    got5_s = 0; got5_f = 0;
    run_frame(2, 255, 0);
    chk("sat_sparse", got5_s, 4'hF);
    chk("sat_full", got5_f, 8'hFF);

    // Alternating stalls must give the same word sequence
    seen.delete();
    run_frame(1, 0, 1);
    chk("stall_len", seen.size(), ref_seq.size());
    for (int i = 0; i < seen.size() && i < ref_seq.size(); i++) chk("stall_word", seen[i], ref_seq[i]);

    // Mid-frame restart: frame A cut at pixel 7, frame B complete
    w0 = n_words; e0 = n_eof;
    for (int i = 0; i < 7; i++) cycle(1, i == 0, i * 10, 0);
    run_frame(1, 0, 0);
    chk("restart_words", n_words - w0, 14);
    chk("restart_eof", n_eof - e0, 1);

    // Random frames with random gaps and thresholds
    for (int f = 0; f < 6; f++) run_frame(3, -1, 2);

    // Reset in the middle of FLUSH, then a non-sof pixel from IDLE
    for (int i = 0; i < NP; i++) cycle(1, i == 0, $urandom_range(0, 255), 3);
    cycle(0, 0, 0, 3);
    cycle(0, 0, 0, 3);
    do_reset();
    w0 = n_words;
    cycle(1, 0, 55, 0);
    repeat (4) cycle(0, 0, 0, 0);
    chk("idle_drop_words", n_words - w0, 0);
    chk("queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/census_transform_frame.md
Name: census_transform_frame

Overview:
- Streaming census transform for the stereo matcher front end. It generalises the fixed checkerboard census to an arbitrary odd WW x WH window, with selectable sparse (checkerboard) or full pattern and a runtime comparison threshold.
- Adds frame awareness: start-of-frame restart, border flagging, end-of-frame marking, and a self-timed flush so every input pixel of a frame produces exactly one census word.
- Sits between the pixel source and the Hamming-cost stage.

Parameters:
- WW, 3, window width; odd, >=3.
- WH, 3, window height; odd, >=3.
- M, 50, image width in pixels.
- H, 50, image height in rows; WH <= H.
- N, 8, pixel bit width.
- SPARSE, 1, 1 = checkerboard pattern, 0 = full window.
- Constraint: (WW-1)/2 + (WH-1)/2 must be even, so the centre lies on an even (r+c) cell.
- Derived CW: (WW*WH)/2 when SPARSE=1; WW*WH-1 when SPARSE=0.

Ports:
- i_clk, in, 1, single clock.
- i_rst, in, 1, reset; synchronous, active-high.
- i_data, in, N, pixel in raster order.
- i_dval, in, 1, pixel valid; a pixel is accepted only when i_dval && o_ready.
- i_sof, in, 1, qualified by acceptance; marks the first pixel of a frame.
- i_thr, in, N, comparison margin.
- o_ready, out, 1, block can accept a pixel.
- o_data, out, CW, census word.
- o_dval, out, 1, o_data valid.
- o_border, out, 1, centre pixel lies within the window half-size of an image edge.
- o_eof, out, 1, marks the last census word of the frame.

Behaviour:
- Window geometry: h=(WW-1)/2, v=(WH-1)/2, latency L = v*M + h pixels.
- Storage: register shift chain of (WH-1)*M+WW pixels; it advances one place per accepted pixel, or per flush cycle with zero injected.
- Window cell (r,c): r=0 is the oldest row, c=0 the oldest column. Centre is (v,h).
- Pattern: SPARSE=1 uses cells with (r+c) odd. SPARSE=0 uses all cells except the centre.
- Bit rule: bit = 1 iff neighbour <= centre + i_thr. The sum is computed at N+1 bits, so it cannot wrap.
- Bit order: selected cells in raster order (r, then c); the first cell maps to o_data[CW-1].
- FSM states and transitions:
  - IDLE: o_ready=1. An accepted pixel with i_sof=1 goes to FILL with pixel count k=1.
  - FILL: o_ready=1. Counts accepted pixels; no output. Goes to STREAM after accepting pixel index L (0-based).
  - STREAM: o_ready=1. Each accepted pixel index k produces the word for centre index k-L on the next cycle. After accepting pixel index M*H-1, goes to FLUSH.
  - FLUSH: o_ready=0; i_dval is ignored. Runs L internal cycles, each producing one word. Then returns to IDLE.
- i_sof=1 on an accepted pixel in FILL or STREAM restarts the frame: k=1, state=FILL, no flush of the old frame, and stale window contents are not cleared.
- i_sof=0 on a pixel accepted in IDLE: the pixel is dropped and the state stays IDLE.
- Output timing: o_data, o_dval, o_border and o_eof are all registered, one cycle after the triggering acceptance or flush cycle.
  - Gaps in i_dval stall the pipeline; o_dval=0 during gaps.
  - Exactly M*H words are produced per completed frame.
- Centre position: centre index p gives y=p/M, x=p%M.
  - o_border=1 when y<v, y>=H-v, x<h or x>=M-h.
  - When o_border=1, o_data is forced to all zeros.
- o_eof=1 with the word for p=M*H-1 only.
- Reset, including mid-frame: state=IDLE, counters=0, shift chain=0, o_data=0, o_dval=0, o_border=0, o_eof=0, o_ready=1 on the cycle after reset is released.

Test Plan:
- Reset and idle: assert i_rst mid-FLUSH -> next cycle o_dval=0, o_ready=1, all outputs 0. Then feed one pixel with i_sof=0 -> no output at all.
- Constant frame (WW=WH=3, M=4, H=3, SPARSE=1, i_thr=0, all pixels 100):
  - First o_dval one cycle after pixel index 5 is accepted.
  - 12 words total; the last 5 come from FLUSH with o_ready=0.
  - Only centres (1,1) and (1,2) give o_border=0, o_data=4'b1111; all others give o_border=1, o_data=0.
  - o_eof on word 12 only.
- Ramp frame (pixel = index*10, same configuration):
  - Centre (1,1) with i_thr=0 -> o_data=4'b1100.
  - Same centre with i_thr=15 -> 4'b1110.
  - With SPARSE=0 (CW=8) and i_thr=0 -> 8'b11110000.
- Saturation: N=8, centre 250, i_thr=255, neighbours 255 -> all bits 1, with no wrap.
- Stalls: toggle i_dval 1/0 each cycle across a frame -> identical word sequence to the unstalled run, with o_dval never asserted on a cycle without an acceptance or flush.
- Mid-frame restart: i_sof at pixel 7 of frame A -> no o_eof for A. Frame B then produces 12 words starting 6 acceptances later.
